keypad_scan: RTL
================

# keypad_scan

Scans a 4x4 active-low key matrix, debounces the result and reports one key at a time. It sits directly upstream of the LCD head-animation controller and drives that controller's `pressed` input; it also supplies a key code and one-cycle press/release pulses for the tone path. It owns the column drive, row synchronisation, frame-level key detection and the debounce state machine.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column is driven; ≥ 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical frames needed to accept a press or a release; ≥ 2.

- `CLK`  in  1  single clock; all logic on rising edge.
- `RESET`  in  1  **synchronous, active-high reset**.
- `ROW`  in  4  matrix rows, active-low with external pull-ups, asynchronous.
- `COL`  out  4  column drive, one-cold; bit c low means column c is active.
- `KEY_CODE`  out  4  accepted key, {row[1:0], col[1:0]}; holds its value after release.
- `PRESSED`  out  1  high while an accepted key is held; feeds the head controller.
- `KEY_VALID`  out  1  one-cycle pulse when a press is accepted.
- `KEY_RELEASE`  out  1  one-cycle pulse when a release is accepted.

## Operation
- Row sync: two-flop synchroniser per `ROW` bit. Reset value is 4'hF.
- Column scan:
  - `div` counts 0..`SCAN_DIV`-1, then wraps to 0; `col_idx` advances 0→1→2→3→0 on each wrap.
  - `COL` = ~(1<<col_idx).
- Sample point: the edge where `div`==`SCAN_DIV`-1. The synchronised row value is captured for the current column.
- Frame accumulation:
  - At each sample, if any synced row bit is 0 and no hit has been recorded yet in this frame, record `frame_hit`=1 and `frame_code`={lowest low row index, col_idx}.
  - Priority is scan order: lower column first, then lower row.
- Frame end: the sample in column 3. The debounce FSM evaluates (`frame_hit`, `frame_code`) including the column-3 sample, then the accumulator clears for the next frame.
- Debounce FSM, evaluated only at frame end:
  - IDLE, hit: `cand`←code, `cnt`←1, go to CONFIRM.
  - IDLE, no hit: stay.
  - CONFIRM, hit with code==`cand`: `cnt`+1. When it reaches `DEBOUNCE_SCANS`:
    - `KEY_CODE`←`cand`, `PRESSED`←1, pulse `KEY_VALID`
    - `cnt`←0, go to HELD.
  - CONFIRM, hit with a different code: `cand`←code, `cnt`←1, stay in CONFIRM.
  - CONFIRM, no hit: go to IDLE; no output change.
  - HELD, hit with code==`KEY_CODE`: `cnt`←0.
  - HELD, otherwise (no hit or a different key): `cnt`+1. When it reaches `DEBOUNCE_SCANS`:
    - `PRESSED`←0, pulse `KEY_RELEASE`
    - go to IDLE; `KEY_CODE` is kept.
- A different key while HELD counts as release evidence. The new key must then debounce from IDLE, so there is never a direct code change while `PRESSED`=1.
- `cnt` width is clog2(`DEBOUNCE_SCANS`+1). `div` width is clog2(`SCAN_DIV`).

## Timing
- Reset values:
  - `COL`=4'b1110, `div`=0, `col_idx`=0
  - `KEY_CODE`=0, `PRESSED`=0, `KEY_VALID`=0, `KEY_RELEASE`=0
  - FSM=IDLE, `cnt`=0, frame accumulator cleared.
- Reset mid-operation (for example while HELD) returns every register to these values on the next edge. No `KEY_RELEASE` pulse is generated.
- Frame period is 4×`SCAN_DIV` cycles.
- Latency from the synchroniser input to the captured value is 2 cycles. `ROW` must be stable from `div`=`SCAN_DIV`-3 through the sample edge.
- `PRESSED`, `KEY_CODE` and `KEY_VALID` update on the same edge as the frame-end sample. `KEY_VALID` is high for exactly one cycle, then 0.
- Minimum press-accept latency: `DEBOUNCE_SCANS` frame ends after first detection. Release-accept latency is the same.
- `KEY_VALID` and `KEY_RELEASE` are never high in the same cycle.
- A press, release, press sequence needs at least 2×`DEBOUNCE_SCANS` frame ends between the two `KEY_VALID` pulses.

## Test plan
- Reset: assert `RESET` for 2 cycles, then release:
  - `COL`=1110, all outputs 0.
  - After `SCAN_DIV` cycles `COL`=1101; after 4×`SCAN_DIV` cycles `COL`=1110 again.
- Clean press of row 2, col 1, with defaults:
  - `KEY_VALID` pulses once at the 4th frame end after first detection.
  - `KEY_CODE`=4'h9, `PRESSED`=1 from that edge.
  - Release: after 4 empty frames `KEY_RELEASE` pulses, `PRESSED`=0, `KEY_CODE` stays 4'h9.
- Bounce: key toggles present/absent on alternate frames for 10 frames, then is steady:
  - No `KEY_VALID` during bouncing.
  - `KEY_VALID` exactly 4 frames into the steady period.
- Simultaneous keys (0,0) and (1,3) held: accepted `KEY_CODE`=4'h0. Only one `KEY_VALID`.
- Key change while HELD, 4'h5 → 4'hA with no gap:
  - `KEY_RELEASE` after 4 frames.
  - `KEY_VALID` with `KEY_CODE`=4'hA after 4 further frames.
- Glitch plus reset:
  - Key present for 3 frames, then absent: no outputs.
  - Assert `RESET` while HELD: `PRESSED`=0 next edge, no `KEY_RELEASE`.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with frame-level debounce.
// Reports one key at a time via PRESSED/KEY_CODE and press/release pulses.
module keypad_scan #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] ROW,
   output logic [3:0] COL,
   output logic [3:0] KEY_CODE,
   output logic       PRESSED,
   output logic       KEY_VALID,
   output logic       KEY_RELEASE
);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONFIRM,
      S_HELD
   } state_t;

   logic [3:0]    r_row_s1;
   logic [3:0]    r_row_s2;
   logic [DW-1:0] r_div;
   logic [1:0]    r_col_idx;
   logic          r_frame_hit;
   logic [3:0]    r_frame_code;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_cand;
   logic [3:0]    r_key_code;
   logic          r_pressed;
   logic          r_valid;
   logic          r_release;

   logic          w_sample;
   logic          w_frame_end;
   logic          w_row_any;
   logic [1:0]    w_row_idx;
   logic          w_hit;
   logic [3:0]    w_code;
   logic [CW-1:0] w_cnt_inc;
   state_t        w_state_nx;
   logic [CW-1:0] w_cnt_nx;
   logic [3:0]    w_cand_nx;
   logic [3:0]    w_key_code_nx;
   logic          w_pressed_nx;
   logic          w_valid_nx;
   logic          w_release_nx;

   assign w_sample    = (r_div == DIV_MAX);
   assign w_frame_end = w_sample && (r_col_idx == 2'd3);
   assign w_row_any   = ~&r_row_s2;
   assign w_cnt_inc   = r_cnt + CNT_ONE;

   always_comb begin
      w_row_idx = 2'd0;
      if (!r_row_s2[0])      w_row_idx = 2'd0;
      else if (!r_row_s2[1]) w_row_idx = 2'd1;
      else if (!r_row_s2[2]) w_row_idx = 2'd2;
      else if (!r_row_s2[3]) w_row_idx = 2'd3;
   end

   // First hit of the frame wins, giving column-then-row priority
   assign w_hit  = r_frame_hit | w_row_any;
   assign w_code = r_frame_hit ? r_frame_code : {w_row_idx, r_col_idx};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_row_s1     <= 4'hF;
         r_row_s2     <= 4'hF;
         r_div        <= '0;
         r_col_idx    <= 2'd0;
         r_frame_hit  <= 1'b0;
         r_frame_code <= 4'h0;
      end else begin
         r_row_s1 <= ROW;
         r_row_s2 <= r_row_s1;
         if (w_sample) begin
            r_div     <= '0;
            r_col_idx <= r_col_idx + 2'd1;
         end else begin
            r_div <= r_div + 1'b1;
         end
         if (w_frame_end) begin
            r_frame_hit  <= 1'b0;
            r_frame_code <= 4'h0;
         end else if (w_sample) begin
            r_frame_hit  <= w_hit;
            r_frame_code <= w_code;
         end
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_cand_nx     = r_cand;
      w_key_code_nx = r_key_code;
      w_pressed_nx  = r_pressed;
      w_valid_nx    = 1'b0;
      w_release_nx  = 1'b0;
      if (w_frame_end) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  w_cand_nx  = w_code;
                  w_cnt_nx   = CNT_ONE;
                  w_state_nx = S_CONFIRM;
               end
            end
            S_CONFIRM: begin
               if (!w_hit) begin
                  w_cnt_nx   = '0;
                  w_state_nx = S_IDLE;
               end else if (w_code != r_cand) begin
                  w_cand_nx = w_code;
                  w_cnt_nx  = CNT_ONE;
               end else if (w_cnt_inc == CNT_MAX) begin
                  w_key_code_nx = r_cand;
                  w_pressed_nx  = 1'b1;
                  w_valid_nx    = 1'b1;
                  w_cnt_nx      = '0;
                  w_state_nx    = S_HELD;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
            S_HELD: begin
               // A different key is release evidence, never a direct swap
               if (w_hit && (w_code == r_key_code)) begin
                  w_cnt_nx = '0;
               end else if (w_cnt_inc == CNT_MAX) begin
                  w_pressed_nx = 1'b0;
                  w_release_nx = 1'b1;
                  w_cnt_nx     = '0;
                  w_state_nx   = S_IDLE;
               end else begin
                  w_cnt_nx = w_cnt_inc;
               end
            end
            default: begin
               w_cnt_nx   = '0;
               w_state_nx = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_cand     <= 4'h0;
         r_key_code <= 4'h0;
         r_pressed  <= 1'b0;
         r_valid    <= 1'b0;
         r_release  <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_cand     <= w_cand_nx;
         r_key_code <= w_key_code_nx;
         r_pressed  <= w_pressed_nx;
         r_valid    <= w_valid_nx;
         r_release  <= w_release_nx;
      end
   end

   assign COL         = ~(4'b0001 << r_col_idx);
   assign KEY_CODE    = r_key_code;
   assign PRESSED     = r_pressed;
   assign KEY_VALID   = r_valid;
   assign KEY_RELEASE = r_release;

endmodule
